// File: rtl/fast_window_ctrl.sv
// fast_window_ctrl
//   Sequences the pixel stream feeding a 7x7 window / FAST-16 circle sampler.
//   It tracks the raster position, drives the window shift enable and
//   qualifies windows that have a full 7x7 neighbourhood. Each valid window
//   is tagged with its centre coordinate and held under downstream
//   backpressure. The block also checks frame sync and reports frame
//   completion.
//   Optional macro FAST_CTRL_PERF_EN adds the perf_stall / perf_frames
//   counters.
module fast_window_ctrl #(
  parameter int COORD_W = 10,
  parameter int MIN_DIM = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic               start,
  output logic               busy,
  input  logic               pix_valid,
  input  logic               pix_sof,
  output logic               pix_ready,
  output logic               shift_en,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               frame_done,
  output logic               err_cfg,
  output logic               err_sync
`ifdef FAST_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_stall,
  output logic [15:0]        perf_frames
`endif
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  // A 7x7 window is complete once the pixel at offset 6 arrives in both axes.
  // Its centre then sits 3 pixels back.
  localparam logic [COORD_W-1:0] WIN_EDGE = COORD_W'(6);
  localparam logic [COORD_W-1:0] WIN_HALF = COORD_W'(3);
  localparam logic [COORD_W-1:0] MIN_SIZE = COORD_W'(MIN_DIM);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [COORD_W-1:0] width_q;
  logic [COORD_W-1:0] height_q;
  // col/row hold the position of the next expected pixel
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] pos_col;
  logic [COORD_W-1:0] pos_row;
  logic               cfg_ok;
  logic               start_ok;
  logic               accept;
  logic               sof_accept;
  logic               col_last;
  logic               last_pix;
  logic               qualify;
  logic               handshake;

  // Handshake, pixel position and qualification decode
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    pix_ready = 1'b0;
    unique case (state)
      S_WAIT_SOF: pix_ready = 1'b1;
      S_ACTIVE:   pix_ready = !win_valid || win_ready;
      default:    pix_ready = 1'b0;
    endcase

    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
    cfg_ok     = (cfg_width >= MIN_SIZE) && (cfg_height >= MIN_SIZE);
    start_ok   = (state == S_IDLE) && start && cfg_ok;
    handshake  = win_valid && win_ready;

    // Outside ACTIVE only an SOF pixel enters the window pipeline. Other
    // pixels are taken and dropped while waiting for frame sync.
    accept     = pix_valid && pix_ready &&
                 ((state == S_ACTIVE) || ((state == S_WAIT_SOF) && pix_sof));
    shift_en   = accept;
    sof_accept = accept && pix_sof;

    // An SOF pixel is always pixel (0,0), whatever the counters say
    pos_col    = pix_sof ? '0 : col;
    pos_row    = pix_sof ? '0 : row;
    col_last   = (pos_col == (width_q - ONE));
    last_pix   = accept && col_last && (pos_row == (height_q - ONE));
    qualify    = accept && (pos_col >= WIN_EDGE) && (pos_row >= WIN_EDGE);
  end

  // Next-state logic for the frame sequencer
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start_ok) state_nxt = S_WAIT_SOF;
      S_WAIT_SOF: if (accept)   state_nxt = S_ACTIVE;
      S_ACTIVE:   if (last_pix) state_nxt = S_DONE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State, latched frame size and raster position counters
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= S_IDLE;
      width_q  <= '0;
      height_q <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
      end
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= pos_row + ONE;
        end else begin
          col <= pos_col + ONE;
          row <= pos_row;
        end
      end
    end
  end

  // Single-cycle error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cfg  <= 1'b0;
      err_sync <= 1'b0;
    end else begin
      err_cfg  <= (state == S_IDLE) && start && !cfg_ok;
      err_sync <= (state == S_ACTIVE) && sof_accept;
    end
  end

  // Window output register: a new window overwrites the one being consumed
  // in the same cycle, so there is no bubble. A mid-frame SOF drops a
  // pending window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
    end else if (qualify) begin
      win_valid <= 1'b1;
      win_x     <= pos_col - WIN_HALF;
      win_y     <= pos_row - WIN_HALF;
    end else if (handshake || ((state == S_ACTIVE) && sof_accept)) begin
      win_valid <= 1'b0;
    end
  end

`ifdef FAST_CTRL_PERF_EN
  // Saturating stall and frame counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall  <= '0;
      perf_frames <= '0;
    end else begin
      if ((state == S_ACTIVE) && pix_valid && !pix_ready && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
      if (frame_done && (perf_frames != '1))
        perf_frames <= perf_frames + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fast_window_ctrl.sv
// tb_fast_window_ctrl
//   Directed bench for fast_window_ctrl. A table of single-cycle vectors
//   covers reset, config rejection and sync entry. Hand-written frame
//   sequences cover raster windows, backpressure, mid-frame SOF and reset
//   mid-frame. Build with FAST_CTRL_PERF_EN to also check the perf counters.
module tb_fast_window_ctrl;

  logic       clk;
  logic       rst;
  logic [9:0] cfg_width;
  logic [9:0] cfg_height;
  logic       start;
  logic       busy;
  logic       pix_valid;
  logic       pix_sof;
  logic       pix_ready;
  logic       shift_en;
  logic       win_valid;
  logic       win_ready;
  logic [9:0] win_x;
  logic [9:0] win_y;
  logic       frame_done;
  logic       err_cfg;
  logic       err_sync;
`ifdef FAST_CTRL_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_frames;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fast_window_ctrl #(.COORD_W(10), .MIN_DIM(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .start      (start),
    .busy       (busy),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .shift_en   (shift_en),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_x      (win_x),
    .win_y      (win_y),
    .frame_done (frame_done),
    .err_cfg    (err_cfg),
    .err_sync   (err_sync)
`ifdef FAST_CTRL_PERF_EN
    ,
    .perf_stall (perf_stall),
    .perf_frames(perf_frames)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       start;
    logic [9:0] w;
    logic [9:0] h;
    logic       pv;
    logic       sof;
    logic       wr;
    logic       e_busy;
    logic       e_prdy;
    logic       e_shift;
    logic       e_wv;
    logic [9:0] e_x;
    logic [9:0] e_y;
    logic       e_done;
    logic       e_ecfg;
    logic       e_esync;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {busy, pix_ready, shift_en, win_valid, win_x, win_y,
                 frame_done, err_cfg, err_sync}, 29'd0);
  endtask

  // Drives one frame and scores it against a raster-order list of expected
  // window centres. When abort_at >= 0, it returns once that many pixels
  // have been accepted, leaving the frame unfinished.
  task automatic run_frame(input int w, input int h, input bit do_stall,
                           input int sof_at, input int abort_at);
    int  q[$];
    int  idx = 0;
    int  cur;
    int  stall_left = 0;
    int  stall_cyc = 0;
    int  done_cnt = 0;
    int  sync_cnt = 0;
    int  win_cnt = 0;
    bit  stall_done = 0;
    bit  sof_done = 0;
    bit  exp_wv = 0;
    bit  exp_wv_nxt;
    bit  acc;
    bit  finished = 0;

    for (int y = 3; y <= h - 4; y++)
      for (int x = 3; x <= w - 4; x++)
        q.push_back((x << 16) | y);

    start = 1'b1; cfg_width = 10'(w); cfg_height = 10'(h);
    pix_valid = 1'b0; pix_sof = 1'b0; win_ready = 1'b1;
    next_cycle();
    start = 1'b0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (abort_at >= 0 && idx >= abort_at) begin
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        return;
      end
      pix_valid = (idx < w * h);
      pix_sof   = (idx == 0) || (idx == sof_at && !sof_done);
      win_ready = (stall_left == 0);
      #4;
      if (done_cnt > 0 && !win_valid) begin
        check("idle after frame", {busy, pix_ready}, 2'b00);
        finished = 1;
        break;
      end
      acc = pix_valid && pix_ready;
      check("shift_en", shift_en, acc);
      check("win_valid timing", win_valid, exp_wv);
      if (win_valid) begin
        if (q.size() == 0) begin
          check("unexpected window", 1'b1, 1'b0);
        end else begin
          check("window centre", {win_x, win_y}, {10'(q[0] >> 16), 10'(q[0] & 16'hffff)});
          if (win_ready) begin
            void'(q.pop_front());
            win_cnt++;
          end
        end
      end
      if (pix_valid && !pix_ready) stall_cyc++;
      if (frame_done) done_cnt++;
      if (err_sync) sync_cnt++;

      cur = pix_sof ? 0 : idx;
      exp_wv_nxt = acc && (cur % w >= 6) && (cur / w >= 6);
      exp_wv = exp_wv_nxt || (exp_wv && !win_ready && !(acc && pix_sof));

      if (stall_left > 0) stall_left--;
      else if (do_stall && !stall_done && win_valid) begin
        stall_left = 3;
        stall_done = 1;
      end

      if (acc) begin
        if (pix_sof && idx != 0) sof_done = 1;
        idx = cur + 1;
      end
      next_cycle();
    end

    check("frame finished in budget", finished, 1'b1);
    check("frame_done pulses", done_cnt, 1);
    check("window count", win_cnt, (w - 6) * (h - 6));
    check("no windows left", q.size(), 0);
    check("err_sync pulses", sync_cnt, (sof_at >= 0) ? 1 : 0);
    check("stall cycles", stall_cyc, do_stall ? 3 : 0);
  endtask

  initial begin
    //          name              rst start  w      h    pv   sof  wr | busy prdy shf  wv   x      y    done ecfg esync
    vecs[0]  = '{"reset state",   1'b1,1'b0,10'd0, 10'd0, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[1]  = '{"start w=6",     1'b0,1'b1,10'd6, 10'd8, 1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[2]  = '{"err_cfg w=6",   1'b0,1'b0,10'd6, 10'd8, 1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,10'd0,10'd0,1'b0,1'b1,1'b0};
    vecs[3]  = '{"err_cfg clears",1'b0,1'b0,10'd6, 10'd8, 1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[4]  = '{"start h=6",     1'b0,1'b1,10'd7, 10'd6, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[5]  = '{"err_cfg h=6",   1'b0,1'b0,10'd7, 10'd6, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,10'd0,10'd0,1'b0,1'b1,1'b0};
    vecs[6]  = '{"start 10x8",    1'b0,1'b1,10'd10,10'd8, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[7]  = '{"drop non-sof",  1'b0,1'b0,10'd10,10'd8, 1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[8]  = '{"start ignored", 1'b0,1'b1,10'd6, 10'd6, 1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[9]  = '{"sof accept",    1'b0,1'b0,10'd10,10'd8, 1'b1,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[10] = '{"active entry",  1'b0,1'b0,10'd10,10'd8, 1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[11] = '{"rst asserted",  1'b1,1'b0,10'd10,10'd8, 1'b1,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};
    vecs[12] = '{"rst applied",   1'b0,1'b0,10'd10,10'd8, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,10'd0,10'd0,1'b0,1'b0,1'b0};

    rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
    pix_valid = 1'b0; pix_sof = 1'b0; win_ready = 1'b1;
    next_cycle();
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; start = vecs[i].start;
      cfg_width = vecs[i].w; cfg_height = vecs[i].h;
      pix_valid = vecs[i].pv; pix_sof = vecs[i].sof; win_ready = vecs[i].wr;
      #4;
      check(vecs[i].name,
            {busy, pix_ready, shift_en, win_valid, win_x, win_y, frame_done, err_cfg, err_sync},
            {vecs[i].e_busy, vecs[i].e_prdy, vecs[i].e_shift, vecs[i].e_wv, vecs[i].e_x,
             vecs[i].e_y, vecs[i].e_done, vecs[i].e_ecfg, vecs[i].e_esync});
      next_cycle();
    end
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;

    // Clean frame, backpressured frame, and mid-frame SOF at pixel 25
    run_frame(10, 8, 1'b0, -1, -1);
    run_frame(10, 8, 1'b1, -1, -1);
    run_frame(10, 8, 1'b0, 25, -1);

    // Reset at row 5, then clean frames again
    run_frame(10, 8, 1'b0, -1, 50);
    #4;
    check("busy before mid-frame rst", busy, 1'b1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #3;
    check_reset_outputs("outputs after mid-frame rst");
`ifdef FAST_CTRL_PERF_EN
    check("perf_stall after rst", perf_stall, 32'd0);
    check("perf_frames after rst", perf_frames, 16'd0);
`endif
    next_cycle();
    run_frame(10, 8, 1'b0, -1, -1);
    run_frame(10, 8, 1'b1, -1, -1);
    // Smallest legal frame has exactly one window, finished in DONE
    run_frame(7, 7, 1'b0, -1, -1);

`ifdef FAST_CTRL_PERF_EN
    #4;
    check("perf_frames", perf_frames, 16'd3);
    check("perf_stall", perf_stall, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
